// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: sequential PC generation, credit-limited memory requests,
// small in-order response FIFO toward decode, redirect flush. Optional macro IFETCH_BYPASS_EN.
module ifetch_buffer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  // Stale requests can pile up across back-to-back redirects while memory is slow,
  // so the in-flight counters get headroom beyond DEPTH.
  localparam int CW = OW + 3;

  logic [29:0]   r_fetch_pc;
  logic [29:0]   r_rsp_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  logic [29:0]   w_fetch_pc_next;
  logic [29:0]   w_rsp_pc_next;
  logic [AW-1:0] w_wr_ptr_next;
  logic [AW-1:0] w_rd_ptr_next;
  logic [OW-1:0] w_count_next;
  logic [CW-1:0] w_out_next;
  logic [CW-1:0] w_drop_next;

  logic          w_empty;
  logic [CW-1:0] w_used;
  logic          w_req_fire;
  logic          w_rsp_live;
  logic          w_rsp_drop;
  logic          w_bypass;
  logic          w_pop;
  logic          w_wr_en;
  logic [29:0]   w_head_pc;
  logic [31:0]   w_head_instr;
  logic [29:0]   w_ent_pc    [DEPTH];
  logic [31:0]   w_ent_instr [DEPTH];
  logic          w_unused;

  assign w_unused = &{1'b0, redirect_pc[1:0]};

  // Credit: slots already filled plus responses still expected to be kept.
  assign w_used         = CW'(r_count) + (r_outstanding - r_drop);
  assign imem_req_valid = !reset && (w_used < CW'(DEPTH));
  assign imem_req_addr  = {r_fetch_pc, 2'b00};
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_live = imem_rsp_valid && (r_drop == '0);
  assign w_empty    = (r_count == '0);

`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_rsp_live && w_empty && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_head_pc    = w_ent_pc[r_rd_ptr];
  assign w_head_instr = w_ent_instr[r_rd_ptr];

  assign id_valid = !w_empty || w_bypass;
  assign id_pc    = w_empty ? {r_rsp_pc, 2'b00} : {w_head_pc, 2'b00};
  always_comb begin
    id_instr = NOP_INSTR;
    if (!w_empty) begin
      id_instr = w_head_instr;
    end else if (w_bypass) begin
      id_instr = imem_rsp_data;
    end
  end

  assign w_pop   = !w_empty && id_ready;
  // A bypassed response that decode takes is never stored.
  assign w_wr_en = w_rsp_live && !(w_bypass && id_ready) && !redirect_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [29:0] r_pc;
      logic [31:0] r_instr;
      always_ff @(posedge clk) begin
        if (w_wr_en && (r_wr_ptr == AW'(gi))) begin
          r_pc    <= r_rsp_pc;
          r_instr <= imem_rsp_data;
        end
      end
      assign w_ent_pc[gi]    = r_pc;
      assign w_ent_instr[gi] = r_instr;
    end
  endgenerate

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    w_rsp_pc_next   = r_rsp_pc;
    w_wr_ptr_next   = r_wr_ptr;
    w_rd_ptr_next   = r_rd_ptr;
    w_count_next    = r_count + OW'(w_wr_en) - OW'(w_pop);
    w_out_next      = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    w_drop_next     = r_drop - CW'(w_rsp_drop);
    if (w_req_fire) begin
      w_fetch_pc_next = r_fetch_pc + 30'd1;
    end
    if (w_rsp_live) begin
      w_rsp_pc_next = r_rsp_pc + 30'd1;
    end
    if (w_wr_en) begin
      w_wr_ptr_next = r_wr_ptr + AW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + AW'(1);
    end
    // Redirect: this cycle's pop has already happened; everything still in flight is stale.
    if (redirect_valid) begin
      w_fetch_pc_next = redirect_pc[31:2];
      w_rsp_pc_next   = redirect_pc[31:2];
      w_wr_ptr_next   = '0;
      w_rd_ptr_next   = '0;
      w_count_next    = '0;
      w_drop_next     = w_out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC[31:2];
      r_rsp_pc      <= RESET_PC[31:2];
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_next;
      r_rsp_pc      <= w_rsp_pc_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_count       <= w_count_next;
      r_outstanding <= w_out_next;
      r_drop        <= w_drop_next;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: in-order memory model tags requests by redirect epoch and
// queues expected decode entries; a monitor pops and compares on every decode handshake.
`timescale 1ns/1ps
module tb_ifetch_buffer;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef IFETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready = 1'b0;

  typedef struct { int due; logic [31:0] addr; int tag; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  mreq_t       m;
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          mem_epoch = 0;
  logic [31:0] exp_pc = RESET_PC;
  int          pop_cnt = 0;
  logic [31:0] last_pop_pc = 32'h0;
  logic        was_reset = 1'b0;

  ifetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'hFFF0_0093;
      32'h8: return 32'h00A0_0113;
      32'hC: return 32'h0020_81B3;
      default: return a ^ 32'h9E37_79B9;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] req);
    if (req_log.size() > idx) chk(name, req_log[idx], req);
    else begin
      checks++; errors++;
      $display("FAIL %s actual=missing required=0x%08h", name, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Memory: in-order, fixed latency per request; live responses queue expected decode entries.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_q.delete();
        mem_epoch++;
        exp_pc = RESET_PC;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          mem_q.push_back('{cyc + mem_lat, imem_req_addr, mem_epoch});
          req_log.push_back(imem_req_addr);
        end
        if (redirect_valid) begin
          mem_epoch++;
          exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m.addr);
        if (m.tag == mem_epoch) begin
          exp_q.push_back('{exp_pc, mem_word(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: compare every decode handshake against the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        was_reset = 1'b1;
        chk("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
      end else begin
        if (was_reset) chk("id_valid_after_reset", {31'd0, id_valid}, 32'd0);
        was_reset = 1'b0;
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pop actual_pc=0x%08h required=none", id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_instr", id_instr, e.instr);
          end
          $display("pop pc=0x%08h instr=0x%08h", id_pc, id_instr);
          pop_cnt++;
          last_pop_pc = id_pc;
        end
        if (redirect_valid) exp_q.delete();
        checks++;
        if (exp_q.size() > DEPTH) begin
          errors++;
          $display("FAIL overflow actual=%0d required<=%0d", exp_q.size(), DEPTH);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int base;
    int first_req;
    int first_idv;
    int p0;
    bit seen;

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, NOP_INSTR);
    chk("rst_id_pc", id_pc, RESET_PC);

    // Sequential fetch, latency 1
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    mem_lat = 1;
    base = req_log.size();
    first_req = -1;
    first_idv = -1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (first_req < 0 && imem_req_valid) first_req = i;
      if (first_idv < 0 && id_valid) first_idv = i;
      tick();
    end
    chk("first_id_valid_latency", 32'(first_idv - first_req), 32'(FIRST_LAT));
    chk_log("seq_addr0", base + 0, 32'h0);
    chk_log("seq_addr1", base + 1, 32'h4);
    chk_log("seq_addr2", base + 2, 32'h8);
    chk_log("seq_addr3", base + 3, 32'hC);

    // Decode stall fills the buffer
    id_ready = 1'b0;
    do_reset();
    base = req_log.size();
    repeat (8) tick();
    #1;
    chk("stall_req_count", 32'(req_log.size() - base), 32'd2);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_id_valid", {31'd0, id_valid}, 32'd1);
    chk("stall_head_pc", id_pc, 32'h0);
    chk("stall_head_instr", id_instr, mem_word(32'h0));
    id_ready = 1'b1;
    repeat (6) tick();
    chk_log("resume_addr", base + 2, 32'h8);

    // Redirect with two stale requests in flight, latency 3
    mem_lat = 3;
    do_reset();
    base = req_log.size();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (req_log.size() - base >= 4) seen = 1'b1;
      else tick();
    end
    chk("d_reached_0xC", {31'd0, seen}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == p0; i++) tick();
    chk("d_first_pc_after_redirect", last_pop_pc, 32'h0000_0100);

    // Redirect together with decode and request handshakes
    mem_lat = 1;
    id_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    id_ready = 1'b1;
    tick();
    chk("e_setup", {29'd0, id_valid, imem_req_valid, imem_rsp_valid}, 32'b110);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("e_empty_after_redirect", {31'd0, id_valid}, 32'd0);
    p0 = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == p0; i++) tick();
    chk("e_first_pc_after_redirect", last_pop_pc, 32'h0000_0200);

    // Unaligned target and PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    chk("f_align_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("f_align_addr", imem_req_addr, 32'h0000_0100);
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("f_top_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("f_top_addr", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("f_wrap_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("f_wrap_addr", imem_req_addr, 32'h0000_0000);
    repeat (6) tick();

    // Random ready/latency with redirects and periodic reset
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      id_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(1, 3);
      reset = ((i % 50) == 49);
      redirect_valid = !reset && ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'h0000_FFFF;
      tick();
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
